// File: rtl/ara_pkg.sv
// rtl/ara_pkg.sv - lane-wide types shared by the VRF writeback stage.
// Result sources, element/strobe/address widths and the queued result entry.
package ara_pkg;

  localparam int unsigned NrResultSources = 4;

  typedef enum logic [1:0] {
    ResAlu,
    ResMfpu,
    ResLdu,
    ResMasku
  } result_source_e;

  typedef logic [63:0] elen_t;
  typedef logic [7:0]  strb_t;
  typedef logic [15:0] vaddr_t;

  typedef struct packed {
    vaddr_t addr;
    elen_t  wdata;
    strb_t  be;
  } result_entry_t;

endpackage

// File: rtl/vrf_writeback_stage_if.sv
// rtl/vrf_writeback_stage_if.sv - result-source and VRF-bank bundle of the writeback stage.
// master = functional units side, slave = writeback stage side.
interface vrf_writeback_stage_if import ara_pkg::*; #(
  parameter int unsigned NrBanks = 8
) ();

  logic   [NrResultSources-1:0] result_req;
  vaddr_t [NrResultSources-1:0] result_addr;
  elen_t  [NrResultSources-1:0] result_wdata;
  strb_t  [NrResultSources-1:0] result_be;
  logic   [NrResultSources-1:0] result_gnt;
  logic   [NrResultSources-1:0] result_pending;
  logic   [NrBanks-1:0]         vrf_req;
  vaddr_t [NrBanks-1:0]         vrf_addr;
  elen_t  [NrBanks-1:0]         vrf_wdata;
  strb_t  [NrBanks-1:0]         vrf_be;

  modport master (
    output result_req, result_addr, result_wdata, result_be,
    input  result_gnt, result_pending, vrf_req, vrf_addr, vrf_wdata, vrf_be
  );

  modport slave (
    input  result_req, result_addr, result_wdata, result_be,
    output result_gnt, result_pending, vrf_req, vrf_addr, vrf_wdata, vrf_be
  );

endinterface

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - small circular FIFO used for the per-source result queues.
// Push while full and pop while empty are ignored; there is no full bypass.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]       cnt_q;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + AddrW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vrf_writeback_stage.sv
// rtl/vrf_writeback_stage.sv - queues results per source and round-robin arbitrates them
// onto single-write-port VRF banks with registered bank outputs.
module vrf_writeback_stage import ara_pkg::*; #(
  parameter int unsigned NrBanks          = 8,
  parameter int unsigned ResultQueueDepth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic   [NrResultSources-1:0] result_req_i,
  input  vaddr_t [NrResultSources-1:0] result_addr_i,
  input  elen_t  [NrResultSources-1:0] result_wdata_i,
  input  strb_t  [NrResultSources-1:0] result_be_i,
  output logic   [NrResultSources-1:0] result_gnt_o,
  output logic   [NrResultSources-1:0] result_pending_o,
  output logic   [NrBanks-1:0]         vrf_req_o,
  output vaddr_t [NrBanks-1:0]         vrf_addr_o,
  output elen_t  [NrBanks-1:0]         vrf_wdata_o,
  output strb_t  [NrBanks-1:0]         vrf_be_o
);
  localparam int unsigned BankW = (NrBanks > 1) ? $clog2(NrBanks) : 1;
  localparam int unsigned SrcW  = $clog2(NrResultSources);
  localparam int unsigned EntW  = $bits(result_entry_t);

  result_entry_t [NrResultSources-1:0]      head;
  logic [NrResultSources-1:0]               q_full, q_empty, q_pop;
  logic [NrResultSources-1:0]               inflight_q;
  logic [NrBanks-1:0][NrResultSources-1:0]  bank_grant;

  for (genvar s = 0; s < NrResultSources; s++) begin : gen_queue
    result_entry_t push_entry;
    assign push_entry = '{addr: result_addr_i[s], wdata: result_wdata_i[s], be: result_be_i[s]};

    fifo_v3 #(
      .DATA_WIDTH (EntW),
      .DEPTH      (ResultQueueDepth)
    ) i_queue (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (1'b0),
      .push_i  (result_req_i[s] && !q_full[s]),
      .data_i  (push_entry),
      .pop_i   (q_pop[s]),
      .data_o  (head[s]),
      .full_o  (q_full[s]),
      .empty_o (q_empty[s])
    );
  end

  assign result_gnt_o     = ~q_full;
  assign result_pending_o = ~q_empty | inflight_q;

  // A head targets one bank only, so OR-ing the bank grants never pops twice.
  always_comb begin
    q_pop = '0;
    for (int unsigned b = 0; b < NrBanks; b++) q_pop |= bank_grant[b];
  end

  // Covers the cycle between dequeue and the registered bank write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) inflight_q <= '0;
    else         inflight_q <= q_pop;
  end

  for (genvar b = 0; b < NrBanks; b++) begin : gen_bank
    logic [SrcW-1:0]            rr_ptr_q, rr_ptr_d, winner, cand;
    logic                       win_valid;
    logic [NrResultSources-1:0] bank_req, grant;
    logic                       req_q;
    vaddr_t                     addr_q;
    elen_t                      wdata_q;
    strb_t                      be_q;

    always_comb begin
      bank_req  = '0;
      grant     = '0;
      win_valid = 1'b0;
      winner    = '0;
      cand      = '0;
      for (int unsigned s = 0; s < NrResultSources; s++) begin
        bank_req[s] = !q_empty[s] && (head[s].addr[BankW-1:0] == BankW'(b));
      end
      for (int unsigned k = 0; k < NrResultSources; k++) begin
        cand = rr_ptr_q + SrcW'(k);
        if (!win_valid && bank_req[cand]) begin
          win_valid = 1'b1;
          winner    = cand;
        end
      end
      if (win_valid) grant[winner] = 1'b1;
      rr_ptr_d = win_valid ? winner + SrcW'(1) : rr_ptr_q;
    end

    assign bank_grant[b] = grant;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rr_ptr_q <= '0;
        req_q    <= 1'b0;
        addr_q   <= '0;
        wdata_q  <= '0;
        be_q     <= '0;
      end else begin
        rr_ptr_q <= rr_ptr_d;
        req_q    <= win_valid;
        if (win_valid) begin
          addr_q  <= head[winner].addr;
          wdata_q <= head[winner].wdata;
          be_q    <= head[winner].be;
        end
      end
    end

    assign vrf_req_o[b]   = req_q;
    assign vrf_addr_o[b]  = addr_q;
    assign vrf_wdata_o[b] = wdata_q;
    assign vrf_be_o[b]    = be_q;
  end

endmodule

// File: tb/tb_vrf_writeback_stage.sv
// tb/tb_vrf_writeback_stage.sv - self-checking bench for vrf_writeback_stage.
// Queue-based reference model plus directed scenarios and random traffic.
module tb_vrf_writeback_stage;
  import ara_pkg::*;

  localparam int NB    = 8;
  localparam int NS    = NrResultSources;
  localparam int DEPTH = 2;

  typedef struct {
    vaddr_t addr;
    elen_t  wdata;
    strb_t  be;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vrf_writeback_stage_if #(.NrBanks(NB)) bus ();

  vrf_writeback_stage #(
    .NrBanks          (NB),
    .ResultQueueDepth (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .result_req_i     (bus.result_req),
    .result_addr_i    (bus.result_addr),
    .result_wdata_i   (bus.result_wdata),
    .result_be_i      (bus.result_be),
    .result_gnt_o     (bus.result_gnt),
    .result_pending_o (bus.result_pending),
    .vrf_req_o        (bus.vrf_req),
    .vrf_addr_o       (bus.vrf_addr),
    .vrf_wdata_o      (bus.vrf_wdata),
    .vrf_be_o         (bus.vrf_be)
  );

  // Reference model: per-source queues, per-bank priority pointer, last bank write.
  ent_t          mq [NS][$];
  int            mptr [NB];
  logic [NS-1:0] m_infl;
  logic [NB-1:0] m_vreq;
  vaddr_t        m_vaddr [NB];
  elen_t         m_vdata [NB];
  strb_t         m_vbe [NB];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) mq[s].delete();
    for (int b = 0; b < NB; b++) begin
      mptr[b]    = 0;
      m_vaddr[b] = '0;
      m_vdata[b] = '0;
      m_vbe[b]   = '0;
    end
    m_infl = '0;
    m_vreq = '0;
  endfunction

  // Advances the model across one clock edge using the inputs currently driven.
  function automatic void model_step();
    logic [NS-1:0] acc, popped;
    int win, s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    popped = '0;
    for (int i = 0; i < NS; i++) acc[i] = bus.result_req[i] && (mq[i].size() < DEPTH);
    for (int b = 0; b < NB; b++) begin
      win = -1;
      for (int k = 0; k < NS; k++) begin
        s = (mptr[b] + k) % NS;
        if (win < 0 && mq[s].size() > 0 && (int'(mq[s][0].addr) % NB) == b) win = s;
      end
      m_vreq[b] = (win >= 0);
      if (win >= 0) begin
        m_vaddr[b]  = mq[win][0].addr;
        m_vdata[b]  = mq[win][0].wdata;
        m_vbe[b]    = mq[win][0].be;
        mptr[b]     = (win + 1) % NS;
        popped[win] = 1'b1;
      end
    end
    for (int i = 0; i < NS; i++) if (popped[i]) void'(mq[i].pop_front());
    for (int i = 0; i < NS; i++)
      if (acc[i]) mq[i].push_back('{addr: bus.result_addr[i], wdata: bus.result_wdata[i], be: bus.result_be[i]});
    m_infl = popped;
  endfunction

  task automatic compare_all();
    logic [NS-1:0] eg, ep;
    for (int s = 0; s < NS; s++) begin
      eg[s] = mq[s].size() < DEPTH;
      ep[s] = (mq[s].size() > 0) || m_infl[s];
    end
    chk("gnt", bus.result_gnt, eg);
    chk("pending", bus.result_pending, ep);
    chk("vrf_req", bus.vrf_req, m_vreq);
    for (int b = 0; b < NB; b++)
      chk($sformatf("bank%0d_bus", b), {bus.vrf_addr[b], bus.vrf_wdata[b], bus.vrf_be[b]},
          {m_vaddr[b], m_vdata[b], m_vbe[b]});
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_drv();
    bus.result_req   = '0;
    bus.result_addr  = '0;
    bus.result_wdata = '0;
    bus.result_be    = '0;
  endtask

  task automatic set_src(input int s, input vaddr_t a, input elen_t d, input strb_t be);
    bus.result_req[s]   = 1'b1;
    bus.result_addr[s]  = a;
    bus.result_wdata[s] = d;
    bus.result_be[s]    = be;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_drv();
    model_reset();
    #1;
    compare_all();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  int       wr_cnt;
  logic     flag;
  int       sent;
  logic     g1;
  elen_t    mfpu_log [$];
  vaddr_t   exp_addr [3];
  vaddr_t   ra;

  initial begin
    clear_drv();
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_gnt", bus.result_gnt, 4'hF);
    chk("reset_pending", bus.result_pending, 4'h0);

    // Single ALU write.
    set_src(0, 16'h0013, 64'hDEAD_BEEF, 8'hFF);
    step();
    clear_drv();
    chk("t32_pend_queued", bus.result_pending[0], 1'b1);
    chk("t32_no_early_write", bus.vrf_req, 8'h00);
    step();
    chk("t32_req", bus.vrf_req, 8'h08);
    chk("t32_addr", bus.vrf_addr[3], 16'h0013);
    chk("t32_wdata", bus.vrf_wdata[3], 64'hDEAD_BEEF);
    chk("t32_be", bus.vrf_be[3], 8'hFF);
    chk("t32_pend_inflight", bus.result_pending[0], 1'b1);
    step();
    chk("t32_pend_clr", bus.result_pending[0], 1'b0);
    chk("t32_req_pulse", bus.vrf_req, 8'h00);
    chk("t32_addr_hold", bus.vrf_addr[3], 16'h0013);

    // Three-way conflict on bank 5, then MASKU leads the next conflict.
    do_reset();
    exp_addr[0] = 16'h0005;
    exp_addr[1] = 16'h0015;
    exp_addr[2] = 16'h0025;
    for (int s = 0; s < 3; s++) set_src(s, exp_addr[s], 64'(s + 1), 8'h0F);
    step();
    clear_drv();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t33_req%0d", i), bus.vrf_req, 8'h20);
      chk($sformatf("t33_addr%0d", i), bus.vrf_addr[5], exp_addr[i]);
    end
    set_src(3, 16'h0035, 64'h33, 8'h00);
    set_src(0, 16'h0045, 64'h44, 8'h01);
    step();
    clear_drv();
    step();
    chk("t33_masku_first", bus.vrf_addr[5], 16'h0035);
    chk("t33_zero_be_written", {bus.vrf_req[5], bus.vrf_be[5]}, {1'b1, 8'h00});
    step();
    chk("t33_alu_second", bus.vrf_addr[5], 16'h0045);

    // Four sources on distinct banks every cycle.
    do_reset();
    wr_cnt = 0;
    flag   = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (bus.result_gnt != 4'hF) flag = 1'b0;
      for (int s = 0; s < NS; s++) set_src(s, vaddr_t'((c << 3) | s), 64'($urandom), 8'($urandom));
      step();
      wr_cnt += $countones(bus.vrf_req);
    end
    clear_drv();
    repeat (3) begin
      step();
      wr_cnt += $countones(bus.vrf_req);
    end
    chk("t34_writes", 128'(wr_cnt), 128'd64);
    chk("t34_gnt_full", flag, 1'b1);

    // MFPU against ALU on bank 2: MFPU queue fills and keeps order.
    do_reset();
    sent = 0;
    flag = 1'b0;
    mfpu_log.delete();
    for (int c = 0; c < 16; c++) begin
      clear_drv();
      if (c < 3) set_src(0, 16'h0002, 64'h8000_0000_0000_0000 | 64'(c), 8'h01);
      if (sent < 6) set_src(1, vaddr_t'(((sent + 1) << 4) | 2), 64'(sent), 8'h02);
      g1 = bus.result_gnt[1];
      step();
      if (bus.result_req[1] && g1) sent++;
      if (!bus.result_gnt[1]) flag = 1'b1;
      if (bus.vrf_req[2] && !bus.vrf_wdata[2][63]) mfpu_log.push_back(bus.vrf_wdata[2]);
    end
    clear_drv();
    chk("t35_gnt_low_seen", flag, 1'b1);
    chk("t35_mfpu_count", 128'(mfpu_log.size()), 128'd6);
    for (int i = 0; i < mfpu_log.size(); i++)
      chk($sformatf("t35_order%0d", i), mfpu_log[i], 64'(i));

    // Reset with two entries queued.
    do_reset();
    set_src(0, 16'h0000, 64'hA0, 8'hFF);
    set_src(1, 16'h0008, 64'hA1, 8'hFF);
    step();
    clear_drv();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    wr_cnt = 0;
    repeat (3) begin
      step();
      wr_cnt += $countones(bus.vrf_req);
    end
    rst_n = 1'b1;
    repeat (3) begin
      step();
      wr_cnt += $countones(bus.vrf_req);
    end
    chk("t36_no_write", 128'(wr_cnt), 128'd0);
    chk("t36_gnt", bus.result_gnt, 4'hF);
    chk("t36_pending", bus.result_pending, 4'h0);

    // Random traffic; a refused request is held until granted.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < NS; s++) begin
        if (!(bus.result_req[s] && !bus.result_gnt[s])) begin
          if ($urandom_range(0, 99) < 65) begin
            ra = vaddr_t'(($urandom_range(0, 8191) << 3) |
                          (($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(0, 7)));
            set_src(s, ra, {$urandom, $urandom}, 8'($urandom));
          end else begin
            bus.result_req[s] = 1'b0;
          end
        end
      end
      step();
    end
    clear_drv();
    repeat (12) step();
    chk("rand_drained", bus.result_pending, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vrf_writeback_stage.md
VRF_WRITEBACK_STAGE -- requirements
Module: vrf_writeback_stage

Interface
REQ-001 SHALL have parameter NrBanks, default 8, number of single-write-port VRF banks in the lane.
REQ-002 SHALL have parameter ResultQueueDepth, default 2, entries per source result queue.
REQ-003 SHALL have port clk_i  input  1  the single clock.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port result_req_i  input  [NrResultSources-1:0]  per-source write request (ALU, MFPU, LDU, MASKU).
REQ-006 SHALL have port result_addr_i  input  vaddr_t [NrResultSources-1:0]  VRF word address; bank = addr[log2(NrBanks)-1:0].
REQ-007 SHALL have port result_wdata_i  input  elen_t [NrResultSources-1:0]  write data.
REQ-008 SHALL have port result_be_i  input  strb_t [NrResultSources-1:0]  byte enables.
REQ-009 SHALL have port result_gnt_o  output  [NrResultSources-1:0]  request accepted into the queue this cycle.
REQ-010 SHALL have port result_pending_o  output  [NrResultSources-1:0]  source has unwritten results (queue non-empty or write in flight).
REQ-011 SHALL have port vrf_req_o  output  [NrBanks-1:0]  per-bank write strobe.
REQ-012 SHALL have port vrf_addr_o  output  vaddr_t [NrBanks-1:0]  per-bank write address.
REQ-013 SHALL have port vrf_wdata_o  output  elen_t [NrBanks-1:0]  per-bank write data.
REQ-014 SHALL have port vrf_be_o  output  strb_t [NrBanks-1:0]  per-bank byte enables.

Function
REQ-015 SHALL hold one FIFO per source, ResultQueueDepth entries, each entry {addr, wdata, be}.
REQ-016 SHALL drive result_gnt_o[s] = queue s not full, independent of result_req_i; no same-cycle full bypass.
REQ-017 SHALL enqueue on result_req_i[s] && result_gnt_o[s]; a request while not granted is ignored, and the source holds it.
REQ-018 SHALL present each non-empty queue head to the arbiter of its target bank.
REQ-019 SHALL arbitrate per bank, round-robin over sources; after a grant, the priority pointer moves to the winner+1 mod NrResultSources; pointer unchanged if no grant.
REQ-020 SHALL dequeue exactly the granted head per bank per cycle; heads targeting different banks SHALL all be served in the same cycle.
REQ-021 SHALL register bank outputs: a head granted in cycle t drives vrf_req_o/addr/wdata/be in cycle t+1 for exactly one cycle; the VRF always accepts writes.
REQ-022 SHALL give request-to-write latency of 2 cycles: accepted at t, written at t+2 with an uncontested bank.
REQ-023 SHALL sustain 1 result/cycle/source with no bank conflicts at ResultQueueDepth=2.
REQ-024 SHALL block a losing head (head-of-line) until it wins; later entries of that source SHALL NOT overtake it.
REQ-025 SHALL keep vrf_addr_o/wdata/be unchanged when vrf_req_o is low.
REQ-026 SHALL deassert result_pending_o[s] only after the source's last write has been driven on vrf_req_o.
REQ-027 SHALL pass be unaltered; all-zero be is still written (strobe asserted).

Reset
REQ-028 SHALL, with rst_ni low, empty all queues, reset all round-robin pointers to source 0, and clear vrf_req_o and result_pending_o to 0; vrf_addr/wdata/be SHALL reset to 0.
REQ-029 SHALL drive result_gnt_o all-ones once queues are empty (including during reset); reset mid-operation SHALL discard queued and in-flight writes without a VRF write.

Structure
REQ-030 SHALL take NrResultSources and enum result_source_e {ResAlu, ResMfpu, ResLdu, ResMasku} from ara_pkg; elen_t, strb_t, and vaddr_t SHALL also come from ara_pkg.
REQ-031 SHALL build queues from the common fifo_v3 sub-module; arbitration SHALL be inline per bank (generate loop).

Verification
REQ-032 SHALL test a single ALU write to addr 0x13 with wdata 0xDEAD_BEEF and be 0xFF -> vrf_req_o[3] pulses at t+2 with the same addr, data, and be, and pending clears in the cycle after.
REQ-033 SHALL test ALU, MFPU, and LDU all writing to bank 5 in the same cycle after reset -> writes land in three consecutive cycles in the order ALU, MFPU, LDU; the next conflict starts with MASKU.
REQ-034 SHALL test four sources targeting banks 0, 1, 2, and 3 every cycle for 16 cycles -> 64 writes with result_gnt_o held at 4'hF.
REQ-035 SHALL test MFPU targeting bank 2 with ALU holding bank 2 for 3 cycles -> the MFPU queue fills, result_gnt_o[1]=0 until a dequeue, and MFPU order is preserved.
REQ-036 SHALL test rst_ni asserted with 2 entries queued -> no VRF write occurs, and after release gnt=4'hF and pending=0.
